dmem_rv32: RTL and testbench

- Parametrised RV32 data memory, the next generation of the single-cycle data RAM.
- Adds a valid/ready request port and a registered response with RV32 load sign/zero extension.
- Adds range and illegal-encoding error reporting, and two-cycle splitting of word-crossing misaligned accesses.
- Sits between the core's load/store unit and a 2**N x 32 word array.

---
 rtl/dmem_rv32.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_rv32.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rv32.sv
// RV32 data memory: valid/ready request port, registered response with load extension,
// range/encoding error reporting and optional two-cycle split of word-crossing accesses.
//
// state    | meaning
// ST_IDLE  | accepting requests; aligned and non-crossing accesses finish here
// ST_SPLIT | second word (w+1) of a word-crossing access is being served
module dmem_rv32 #(
   parameter int N              = 10,
   parameter bit MISALIGN_SPLIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = 2 ** N;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SPLIT = 1'b1
   } state_t;

   // Reset leaves contents alone; power-up state is all zeros.
   logic [31:0] ram [0:DEPTH-1] = '{default: 32'h0};

   state_t        state_q, state_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          we_q, we_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [N-1:0]  widx1_q, widx1_d;
   logic [31:0]   lo_q, lo_d;

   logic          mem_we;
   logic [N-1:0]  mem_widx;
   logic [3:0]    mem_wbe;
   logic [31:0]   mem_wdata;

   logic [1:0]    off;
   logic [N-1:0]  widx;
   logic          legal;
   logic          range_bad;
   logic          crossing;
   logic          last_word;
   logic          req_err;
   logic [7:0]    be8, be8_s;
   logic [63:0]   data64, data64_s;
   logic [31:0]   rd_lo, rd_hi;

   function automatic logic [7:0] lane_be(input logic [1:0] sz, input logic [1:0] o);
      logic [7:0] base;
      case (sz)
         2'b00:   base = 8'h01;
         2'b01:   base = 8'h03;
         default: base = 8'h0F;
      endcase
      return base << o;
   endfunction

   function automatic logic [63:0] lane_data(input logic [31:0] wd, input logic [1:0] o);
      return {32'h0, wd} << {o, 3'b000};
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [63:0] pair,
                                            input logic [1:0] o);
      logic [63:0] sh;
      logic [31:0] d;
      logic [31:0] r;
      sh = pair >> {o, 3'b000};
      d  = sh[31:0];
      case (f3)
         3'b000:  r = {{24{d[7]}}, d[7:0]};
         3'b001:  r = {{16{d[15]}}, d[15:0]};
         3'b100:  r = {24'h0, d[7:0]};
         3'b101:  r = {16'h0, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   assign off       = req_addr[1:0];
   assign widx      = req_addr[N+1:2];
   assign legal     = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                             : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign range_bad = (req_addr >> (N + 2)) != 32'd0;
   assign crossing  = ((req_funct3[1:0] == 2'b01) && (off == 2'b11)) ||
                      ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
   // The second word of a split must not wrap around to word 0.
   assign last_word = (widx == {N{1'b1}});
   assign req_err   = !legal || range_bad || (crossing && (!MISALIGN_SPLIT || last_word));

   assign be8      = lane_be(req_funct3[1:0], off);
   assign data64   = lane_data(req_wdata, off);
   assign be8_s    = lane_be(funct3_q[1:0], off_q);
   assign data64_s = lane_data(wdata_q, off_q);

   assign rd_lo = ram[widx];
   assign rd_hi = ram[widx1_q];

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
      we_d        = we_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      widx1_d     = widx1_q;
      lo_d        = lo_q;
      mem_we      = 1'b0;
      mem_widx    = widx;
      mem_wbe     = 4'h0;
      mem_wdata   = 32'h0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  mem_we    = req_we;
                  mem_wbe   = be8[3:0];
                  mem_wdata = data64[31:0];
                  if (crossing) begin
                     state_d  = ST_SPLIT;
                     we_d     = req_we;
                     funct3_d = req_funct3;
                     off_d    = off;
                     wdata_d  = req_wdata;
                     widx1_d  = widx + N'(1);
                     lo_d     = rd_lo;
                  end else begin
                     rsp_valid_d = 1'b1;
                     if (!req_we)
                        rsp_rdata_d = load_ext(req_funct3, {32'h0, rd_lo}, off);
                  end
               end
            end
         end
         ST_SPLIT: begin
            mem_we      = we_q;
            mem_widx    = widx1_q;
            mem_wbe     = be8_s[7:4];
            mem_wdata   = data64_s[63:32];
            rsp_valid_d = 1'b1;
            if (!we_q)
               rsp_rdata_d = load_ext(funct3_q, {rd_hi, lo_q}, off_q);
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         wdata_q     <= 32'h0;
         widx1_q     <= '0;
         lo_q        <= 32'h0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         wdata_q     <= wdata_d;
         widx1_q     <= widx1_d;
         lo_q        <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < 4; k++) begin
            if (mem_wbe[k])
               ram[mem_widx][8*k +: 8] <= mem_wdata[8*k +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_rv32.sv
// Bench for dmem_rv32: directed requests push expected responses into per-instance
// queues; monitors pop and compare data, error flag and response cycle.
module tb_dmem_rv32;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
   logic [2:0]  a_req_funct3;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
   logic [2:0]  b_req_funct3;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

   dmem_rv32 #(.N(10), .MISALIGN_SPLIT(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   dmem_rv32 #(.N(4), .MISALIGN_SPLIT(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit rdy(input bit d);
      return d ? (b_req_ready == 1'b1) : (a_req_ready == 1'b1);
   endfunction

   task automatic req(input bit d, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int lat);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge clk);
      while (!rdy(d) && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (!rdy(d)) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: req_ready stayed 0, expected 1 (addr %h)", addr);
         return;
      end
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.due   = cyc + lat;
      if (d) begin
         b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = f3;
         b_req_addr = addr; b_req_wdata = wd;
         q_b.push_back(e);
      end else begin
         a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3;
         a_req_addr = addr; a_req_wdata = wd;
         q_a.push_back(e);
      end
   endtask

   task automatic idle(input bit d);
      @(negedge clk);
      if (d) b_req_valid = 1'b0;
      else   a_req_valid = 1'b0;
   endtask

   task automatic mon(input bit d, input logic v, input logic [31:0] rd, input logic er);
      exp_t  e;
      string tag;
      int    sz;
      tag = d ? "b" : "a";
      sz  = d ? q_b.size() : q_a.size();
      if (v) begin
         if (sz == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_rsp: rsp_valid=1 with rdata %h, expected no response", tag, rd);
         end else begin
            if (d) e = q_b.pop_front();
            else   e = q_a.pop_front();
            chk({tag, "_rdata"}, rd, e.rdata);
            chk({tag, "_err"}, {31'h0, er}, {31'h0, e.err});
            chk({tag, "_latency"}, cyc, e.due);
         end
      end else begin
         chk({tag, "_idle_rdata"}, rd, 32'h0);
         chk({tag, "_idle_err"}, {31'h0, er}, 32'h0);
         if (sz != 0) begin
            if (d) e = q_b[0];
            else   e = q_a[0];
            if (cyc > e.due) begin
               n_checks++;
               n_fail++;
               $display("FAIL %s_rsp_timeout: no response at cycle %0d, expected by %0d", tag, cyc, e.due);
               if (d) void'(q_b.pop_front());
               else   void'(q_a.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) if (rst_n) mon(1'b0, a_rsp_valid, a_rsp_rdata, a_rsp_err);
   always @(negedge clk) if (rst_n) mon(1'b1, b_rsp_valid, b_rsp_rdata, b_rsp_err);

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
      b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
      repeat (3) @(negedge clk);
      chk("rst_a_valid", {31'h0, a_rsp_valid}, 32'h0);
      chk("rst_a_rdata", a_rsp_rdata, 32'h0);
      chk("rst_a_err", {31'h0, a_rsp_err}, 32'h0);
      chk("rst_a_ready", {31'h0, a_req_ready}, 32'h1);
      chk("rst_b_ready", {31'h0, b_req_ready}, 32'h1);
      rst_n = 1'b1;

      // Word store then back-to-back loads of every width at every offset.
      req(0, 1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
      req(0, 0, F_B,  32'h10, 32'h0,        32'hFFFFFFEF, 0, 1);
      req(0, 0, F_B,  32'h11, 32'h0,        32'hFFFFFFBE, 0, 1);
      req(0, 0, F_B,  32'h12, 32'h0,        32'hFFFFFFAD, 0, 1);
      req(0, 0, F_B,  32'h13, 32'h0,        32'hFFFFFFDE, 0, 1);
      req(0, 0, F_BU, 32'h13, 32'h0,        32'h000000DE, 0, 1);
      req(0, 0, F_BU, 32'h10, 32'h0,        32'h000000EF, 0, 1);
      req(0, 0, F_H,  32'h10, 32'h0,        32'hFFFFBEEF, 0, 1);
      req(0, 0, F_H,  32'h12, 32'h0,        32'hFFFFDEAD, 0, 1);
      req(0, 0, F_HU, 32'h12, 32'h0,        32'h0000DEAD, 0, 1);
      req(0, 0, F_H,  32'h11, 32'h0,        32'hFFFFADBE, 0, 1);
      req(0, 0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 0, 1);

      // Sub-word stores touch only their own lanes.
      req(0, 1, F_W,  32'h20, 32'h0,        32'h0,        0, 1);
      req(0, 1, F_B,  32'h21, 32'hFFFFFFAA, 32'h0,        0, 1);
      req(0, 1, F_H,  32'h22, 32'hABCD1234, 32'h0,        0, 1);
      req(0, 0, F_W,  32'h20, 32'h0,        32'h1234AA00, 0, 1);
      req(0, 0, F_W,  32'h1C, 32'h0,        32'h0,        0, 1);
      req(0, 0, F_W,  32'h24, 32'h0,        32'h0,        0, 1);
      idle(0);

      // Word-crossing store split over two cycles.
      req(0, 1, F_W,  32'h03, 32'h11223344, 32'h0,        0, 2);
      @(negedge clk);
      a_req_valid = 1'b0;
      chk("split_ready_low", {31'h0, a_req_ready}, 32'h0);
      req(0, 0, F_W,  32'h00, 32'h0,        32'h44000000, 0, 1);
      req(0, 0, F_W,  32'h04, 32'h0,        32'h00112233, 0, 1);
      req(0, 0, F_W,  32'h03, 32'h0,        32'h11223344, 0, 2);
      req(0, 0, F_HU, 32'h03, 32'h0,        32'h00003344, 0, 2);
      req(0, 0, F_W,  32'h08, 32'h0,        32'h0,        0, 1);

      // Illegal encodings and out-of-range addresses.
      req(0, 0, 3'b011, 32'h10,  32'h0,        32'h0, 1, 1);
      req(0, 0, 3'b110, 32'h10,  32'h0,        32'h0, 1, 1);
      req(0, 0, 3'b111, 32'h10,  32'h0,        32'h0, 1, 1);
      req(0, 1, F_BU,   32'h10,  32'h00000099, 32'h0, 1, 1);
      req(0, 1, F_HU,   32'h12,  32'h00009999, 32'h0, 1, 1);
      req(0, 0, F_W,    32'h10,  32'h0,        32'hDEADBEEF, 0, 1);
      req(0, 0, F_W,    32'h1000, 32'h0,       32'h0, 1, 1);
      req(0, 1, F_W,    32'h1000, 32'h12345678, 32'h0, 1, 1);
      req(0, 1, F_W,    32'h80000000, 32'h12345678, 32'h0, 1, 1);
      req(0, 0, F_W,    32'h00,  32'h0,        32'h44000000, 0, 1);
      req(0, 1, F_W,    32'hFFD, 32'hCAFEBABE, 32'h0, 1, 1);
      req(0, 0, F_W,    32'hFFC, 32'h0,        32'h0, 0, 1);
      req(0, 0, F_W,    32'h00,  32'h0,        32'h44000000, 0, 1);

      // Reset in the middle of a split store.
      req(0, 1, F_W,    32'h08,  32'h55667788, 32'h0, 0, 1);
      @(negedge clk);
      chk("rst_split_pre_ready", {31'h0, a_req_ready}, 32'h1);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = F_W;
      a_req_addr = 32'h06; a_req_wdata = 32'hAABBCCDD;
      @(negedge clk);
      a_req_valid = 1'b0;
      chk("rst_split_busy", {31'h0, a_req_ready}, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_split_valid", {31'h0, a_rsp_valid}, 32'h0);
      chk("rst_split_rdata", a_rsp_rdata, 32'h0);
      chk("rst_split_err", {31'h0, a_rsp_err}, 32'h0);
      chk("rst_split_ready", {31'h0, a_req_ready}, 32'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      req(0, 0, F_W,    32'h04,  32'h0,        32'hCCDD2233, 0, 1);
      req(0, 0, F_W,    32'h08,  32'h0,        32'h55667788, 0, 1);
      idle(0);

      // Small array with crossing accesses rejected.
      req(1, 1, F_W,    32'h3F,  32'h12345678, 32'h0, 1, 1);
      req(1, 0, F_W,    32'h3C,  32'h0,        32'h0, 0, 1);
      req(1, 0, F_W,    32'h40,  32'h0,        32'h0, 1, 1);
      req(1, 1, F_W,    32'h04,  32'hCAFEF00D, 32'h0, 0, 1);
      req(1, 0, F_W,    32'h05,  32'h0,        32'h0, 1, 1);
      req(1, 0, F_H,    32'h05,  32'h0,        32'hFFFFFEF0, 0, 1);
      req(1, 0, F_HU,   32'h06,  32'h0,        32'h0000CAFE, 0, 1);
      req(1, 0, F_H,    32'h07,  32'h0,        32'h0, 1, 1);
      req(1, 1, F_H,    32'h07,  32'h00005555, 32'h0, 1, 1);
      req(1, 0, F_B,    32'h07,  32'h0,        32'hFFFFFFCA, 0, 1);
      req(1, 0, F_W,    32'h04,  32'h0,        32'hCAFEF00D, 0, 1);
      req(1, 0, F_W,    32'h08,  32'h0,        32'h0, 0, 1);
      idle(1);

      repeat (5) @(negedge clk);
      chk("a_queue_drained", q_a.size(), 32'h0);
      chk("b_queue_drained", q_b.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
